// File: rtl/vga_vertical_timing_gen.sv
// Vertical VGA timing: line counter, SYNC/BACK/ACTIVE/FRONT phase FSM, scaled VRAM row index.
// All outputs registered; everything advances only on new_line, synchronous active-high reset.
module vga_vertical_timing_gen #(
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 29,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10,
  parameter int SCALE    = 5,
  parameter bit SYNC_POL = 1'b0,
  parameter int CNT_W    = 10,
  parameter int SCL_W    = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             new_line,
  output logic [CNT_W-1:0] ver_cnt,
  output logic [SCL_W-1:0] scl_ver_cnt,
  output logic             VSYNC,
  output logic             v_active,
  output logic             frame_start,
  output logic             row_advance
);

  localparam int TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
  localparam int A0    = V_SYNC + V_BACK;
  localparam int A1    = A0 + V_ACTIVE;
  localparam int SC_W  = (SCALE > 1) ? $clog2(SCALE) : 1;

  localparam logic [CNT_W-1:0] LAST_LINE = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] SYNC_END  = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] ACT_BEG   = CNT_W'(A0);
  localparam logic [CNT_W-1:0] ACT_END   = CNT_W'(A1);
  localparam logic [SC_W-1:0]  SC_LAST   = SC_W'(SCALE - 1);

  typedef enum logic [1:0] {SYNC, BACK, ACTIVE, FRONT} state_t;

  // Phase is a pure function of the line index, so zero-length phases fall out naturally.
  function automatic state_t phase_of(input logic [CNT_W-1:0] line);
    state_t ph;
    if (line < SYNC_END)     ph = SYNC;
    else if (line < ACT_BEG) ph = BACK;
    else if (line < ACT_END) ph = ACTIVE;
    else                     ph = FRONT;
    return ph;
  endfunction

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SC_W-1:0]   sc_q, sc_d;
  logic [SCL_W-1:0]  scl_q, scl_d;
  logic              vsync_q, vsync_d;
  logic              act_q, act_d;
  logic              fs_q, fs_d;
  logic              ra_q, ra_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SYNC;
      cnt_q   <= '0;
      sc_q    <= '0;
      scl_q   <= '0;
      vsync_q <= SYNC_POL;
      act_q   <= 1'b0;
      fs_q    <= 1'b0;
      ra_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sc_q    <= sc_d;
      scl_q   <= scl_d;
      vsync_q <= vsync_d;
      act_q   <= act_d;
      fs_q    <= fs_d;
      ra_q    <= ra_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sc_d    = sc_q;
    scl_d   = scl_q;
    vsync_d = vsync_q;
    act_d   = act_q;
    fs_d    = 1'b0;
    ra_d    = 1'b0;
    if (new_line) begin
      cnt_d   = (cnt_q == LAST_LINE) ? '0 : cnt_q + CNT_W'(1);
      state_d = phase_of(cnt_d);
      fs_d    = (cnt_q == LAST_LINE);
      vsync_d = (state_d == SYNC) ? SYNC_POL : ~SYNC_POL;
      act_d   = (state_d == ACTIVE);
      sc_d    = '0;
      scl_d   = '0;
      // Only lines that stay inside ACTIVE advance the scaler; exit clears without a row pulse.
      if (state_d == ACTIVE && state_q == ACTIVE) begin
        scl_d = scl_q;
        if (sc_q == SC_LAST) begin
          scl_d = scl_q + SCL_W'(1);
          ra_d  = 1'b1;
        end else begin
          sc_d = sc_q + SC_W'(1);
        end
      end
    end
  end

  assign ver_cnt     = cnt_q;
  assign scl_ver_cnt = scl_q;
  assign VSYNC       = vsync_q;
  assign v_active    = act_q;
  assign frame_start = fs_q;
  assign row_advance = ra_q;

endmodule
